// File: rtl/pitch_pkg.sv
// ============================================================================
// Module : pitch_pkg
// Brief  : Shared mode codes, speed limit, FSM states and step-period helper
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pitch_pkg;

    localparam logic [1:0] FASTBALL  = 2'd1;
    localparam logic [1:0] SLIDER    = 2'd2;
    localparam logic [1:0] CHANGE_UP = 2'd3;

    localparam logic [3:0] SPEED_MAX = 4'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WINDUP = 2'd1,
        FLIGHT = 2'd2,
        ARRIVE = 2'd3
    } state_t;

    // Change-up decelerates over the second half of the flight path.
    function automatic logic [31:0] step_period(input logic [31:0] step_cyc,
                                                input logic [1:0]  md,
                                                input logic [3:0]  pos);
        if ((md == CHANGE_UP) && pos[3])
            return step_cyc << 1;
        return step_cyc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pitch_flight_seq_step_timer.sv
// ============================================================================
// Module : step_timer
// Brief  : Loadable 32-bit down-counter; tick is high in the last counted cycle
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module step_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        tick
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != 32'd0)
            cnt_d = cnt_q - 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 32'd0;
        else
            cnt_q <= cnt_d;
    end

    // A load of N yields exactly N cycles before the tick-driven transition.
    assign tick = (cnt_q == 32'd1);

endmodule

`default_nettype wire

// File: rtl/pitch_flight_seq.sv
// ============================================================================
// Module : pitch_flight_seq
// Brief  : Pitch animation sequencer (wind-up, flight, arrival) on 16 LEDs.
//          Optional flight-duration timer enabled by macro PITCH_TIMER_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pitch_flight_seq
    import pitch_pkg::*;
#(
    parameter int unsigned BASE_STEP_CYC = 6_250_000,
    parameter int unsigned STEP_DEC_CYC  = 250_000,
    parameter int unsigned WINDUP_CYC    = 25_000_000,
    parameter int unsigned HOLD_CYC      = 50_000_000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        pitch,
    input  logic [3:0]  speedCode,
    input  logic [1:0]  mode,
    output logic [15:0] LED,
    output logic [3:0]  ballPos,
    output logic        busy,
    output logic        done,
    output logic [31:0] flightCyc
);

    state_t      state_q, state_d;
    logic        pitch_d_q;
    logic        arm_block_q, arm_block_d;
    logic [3:0]  spd_q, spd_d;
    logic [1:0]  md_q, md_d;
    logic [3:0]  pos_q, pos_d;
    logic        done_q, done_d;
    logic        w_start;
    logic [31:0] w_step_cyc;
    logic        w_tmr_load;
    logic [31:0] w_tmr_val;
    logic        w_tick;

    // A pitch held through reset release must first be seen low before it can start.
    assign arm_block_d = arm_block_q & pitch;
    assign w_start     = (state_q == IDLE) && pitch && !pitch_d_q && !arm_block_q;
    assign w_step_cyc  = 32'(BASE_STEP_CYC) - (32'(spd_q) * 32'(STEP_DEC_CYC));

    always_comb begin
        state_d    = state_q;
        spd_d      = spd_q;
        md_d       = md_q;
        pos_d      = pos_q;
        done_d     = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_val  = 32'd0;
        case (state_q)
            IDLE: begin
                pos_d = 4'd0;
                if (w_start) begin
                    state_d    = WINDUP;
                    spd_d      = (speedCode > SPEED_MAX) ? SPEED_MAX : speedCode;
                    md_d       = (mode == 2'd0) ? FASTBALL : mode;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = 32'(WINDUP_CYC);
                end
            end
            WINDUP: begin
                if (w_tick) begin
                    state_d    = FLIGHT;
                    pos_d      = 4'd0;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = step_period(w_step_cyc, md_q, 4'd0);
                end
            end
            FLIGHT: begin
                if (w_tick) begin
                    w_tmr_load = 1'b1;
                    if (pos_q == 4'd15) begin
                        state_d   = ARRIVE;
                        done_d    = 1'b1;
                        w_tmr_val = 32'(HOLD_CYC);
                    end else begin
                        pos_d     = pos_q + 4'd1;
                        w_tmr_val = step_period(w_step_cyc, md_q, pos_q + 4'd1);
                    end
                end
            end
            ARRIVE: begin
                if (w_tick) begin
                    state_d = IDLE;
                    pos_d   = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            pitch_d_q   <= 1'b0;
            arm_block_q <= 1'b1;
            spd_q       <= 4'd0;
            md_q        <= FASTBALL;
            pos_q       <= 4'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pitch_d_q   <= pitch;
            arm_block_q <= arm_block_d;
            spd_q       <= spd_d;
            md_q        <= md_d;
            pos_q       <= pos_d;
            done_q      <= done_d;
        end
    end

    step_timer u_step_timer (
        .clk      (clk),
        .rst_n    (rstN),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .tick     (w_tick)
    );

    always_comb begin
        LED = 16'h0000;
        case (state_q)
            WINDUP: LED = 16'h8000;
            FLIGHT: begin
                LED = 16'd1 << (4'd15 - pos_q);
                // Slider break: the trailing neighbour lights over the last four positions.
                if ((md_q == SLIDER) && (pos_q >= 4'd12))
                    LED = LED | (16'd1 << (5'd16 - {1'b0, pos_q}));
            end
            ARRIVE:  LED = 16'h0001;
            default: LED = 16'h0000;
        endcase
    end

    assign ballPos = pos_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

`ifdef PITCH_TIMER_EN
    logic [31:0] fcnt_q, fcnt_d;
    logic [31:0] fcyc_q, fcyc_d;

    always_comb begin
        fcnt_d = fcnt_q;
        fcyc_d = fcyc_q;
        if (w_start)
            fcnt_d = 32'd0;
        else if (state_q == FLIGHT)
            fcnt_d = fcnt_q + 32'd1;
        // Include the final FLIGHT cycle that is being counted on this edge.
        if (done_d)
            fcyc_d = fcnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fcnt_q <= 32'd0;
            fcyc_q <= 32'd0;
        end else begin
            fcnt_q <= fcnt_d;
            fcyc_q <= fcyc_d;
        end
    end

    assign flightCyc = fcyc_q;
`else
    assign flightCyc = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pitch_flight_seq.sv
// ============================================================================
// Module : tb_pitch_flight_seq
// Brief  : Self-checking bench; per-cycle expected frames built from the pitch rules
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pitch_flight_seq;

    localparam int BASE = 20;
    localparam int DEC  = 2;
    localparam int WIN  = 5;
    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        pitch = 1'b0;
    logic [3:0]  speedCode = 4'd0;
    logic [1:0]  mode = 2'd1;
    logic [15:0] LED;
    logic [3:0]  ballPos;
    logic        busy;
    logic        done;
    logic [31:0] flightCyc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pitch_flight_seq #(
        .BASE_STEP_CYC (BASE),
        .STEP_DEC_CYC  (DEC),
        .WINDUP_CYC    (WIN),
        .HOLD_CYC      (HOLD)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .pitch     (pitch),
        .speedCode (speedCode),
        .mode      (mode),
        .LED       (LED),
        .ballPos   (ballPos),
        .busy      (busy),
        .done      (done),
        .flightCyc (flightCyc)
    );

    function automatic int model_period(int sc, int md, int pos);
        int s  = (sc > 8) ? 8 : sc;
        int st = BASE - s * DEC;
        int m  = (md == 0) ? 1 : md;
        if (m == 3 && pos >= 8) return 2 * st;
        return st;
    endfunction

    function automatic logic [15:0] model_led(int md, int pos);
        logic [15:0] l;
        int m = (md == 0) ? 1 : md;
        l = 16'd1 << (15 - pos);
        if (m == 2 && pos >= 12) l = l | (16'd1 << (16 - pos));
        return l;
    endfunction

    // One full pitch: expected {LED, ballPos, busy, done} per cycle from the press onward.
    task automatic run_pitch(input string name, input int sc, input int md, input bit disturb);
        logic [21:0] q[$];
        logic [21:0] obs;
        int flight = 0;
        int exp_fc;
        for (int i = 0; i < WIN; i++) q.push_back({16'h8000, 4'd0, 1'b1, 1'b0});
        for (int p = 0; p < 16; p++) begin
            int per = model_period(sc, md, p);
            flight += per;
            for (int c = 0; c < per; c++) q.push_back({model_led(md, p), 4'(p), 1'b1, 1'b0});
        end
        for (int h = 0; h < HOLD; h++) q.push_back({16'h0001, 4'd15, 1'b1, (h == 0)});
        q.push_back({16'h0000, 4'd0, 1'b0, 1'b0});

        @(negedge clk);
        speedCode = 4'(sc);
        mode      = 2'(md);
        pitch     = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < q.size(); i++) begin
            if (i == 1) pitch = 1'b0;
            if (disturb && i == WIN + 10) begin
                speedCode = 4'($urandom_range(0, 15));
                mode      = 2'($urandom_range(0, 3));
                pitch     = 1'b1;
            end
            if (disturb && i == WIN + 12) pitch = 1'b0;
            obs = {LED, ballPos, busy, done};
            checks++;
            if (obs !== q[i]) begin
                errors++;
                $display("FAIL %s frame %0d: got led=%h pos=%0d busy=%b done=%b, want led=%h pos=%0d busy=%b done=%b",
                         name, i, obs[21:6], obs[5:2], obs[1], obs[0],
                         q[i][21:6], q[i][5:2], q[i][1], q[i][0]);
            end
            @(posedge clk); #1;
        end
`ifdef PITCH_TIMER_EN
        exp_fc = flight;
`else
        exp_fc = 0;
`endif
        checks++;
        if (flightCyc !== 32'(exp_fc)) begin
            errors++;
            $display("FAIL %s flightCyc: got %0d want %0d", name, flightCyc, exp_fc);
        end
    endtask

    task automatic test_reset();
        rstN  = 1'b0;
        pitch = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({LED, ballPos, busy, done, flightCyc} !== 54'd0) begin
            errors++;
            $display("FAIL reset_state: got led=%h pos=%0d busy=%b done=%b fc=%0d want all zero",
                     LED, ballPos, busy, done, flightCyc);
        end
        @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fastball();  run_pitch("fastball_s0", 0, 1, 1'b0);  endtask
    task automatic test_change_up(); run_pitch("changeup_s8", 8, 3, 1'b0);  endtask
    task automatic test_slider();    run_pitch("slider_s3", 3, 2, 1'b0);    endtask
    task automatic test_clamp();     run_pitch("clamp_s15", 15, 1, 1'b0);   endtask
    task automatic test_mode0();     run_pitch("mode0_s5", 5, 0, 1'b0);     endtask
    task automatic test_disturb();   run_pitch("disturb_s2", 2, 3, 1'b1);   endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            int sc = $urandom_range(0, 15);
            int md = $urandom_range(0, 3);
            run_pitch($sformatf("random%0d_s%0d_m%0d", k, sc, md), sc, md, 1'b1);
        end
    endtask

    task automatic test_reset_mid_flight();
        int n = 0;
        bit found = 0;
        @(negedge clk);
        speedCode = 4'd0;
        mode      = 2'd1;
        pitch     = 1'b1;
        @(posedge clk); #1;
        pitch = 1'b0;
        while (!found && n < 1000) begin
            if (busy && ballPos == 4'd6 && LED == 16'h0200) found = 1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        checks++;
        if (!found || n != WIN + 6 * BASE) begin
            errors++;
            $display("FAIL midreset_reach_pos6: got found=%0b after %0d cycles want %0d cycles",
                     found, n, WIN + 6 * BASE);
        end
        repeat (3) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if ({LED, ballPos, busy, done} !== 22'd0) begin
            errors++;
            $display("FAIL midreset_immediate: got led=%h pos=%0d busy=%b done=%b want all zero",
                     LED, ballPos, busy, done);
        end
        @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        run_pitch("after_midreset", 0, 1, 1'b0);
    endtask

    task automatic test_held_reset();
        @(negedge clk);
        pitch = 1'b1;
        rstN  = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL held_pitch_no_start cycle %0d: got busy=%b want 0", i, busy);
            end
        end
        @(negedge clk);
        pitch = 1'b0;
        repeat (2) @(negedge clk);
        run_pitch("after_held_release", 4, 2, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fastball();
        test_change_up();
        test_slider();
        test_clamp();
        test_mode0();
        test_disturb();
        test_random();
        test_reset_mid_flight();
        test_held_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
